// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared combinational adder: grants a requester,
// registers its operands onto the adder, captures the sum and returns it with the requester ID.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         add_r1,
    output logic [WIDTH-1:0]         add_r2,
    input  logic [WIDTH-1:0]         add_rst,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_sum,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [WIDTH-1:0]    add_r1_q, add_r1_d;
    logic [WIDTH-1:0]    add_r2_q, add_r2_d;
    logic [WIDTH-1:0]    resp_sum_q, resp_sum_d;
    logic                resp_valid_q, resp_valid_d;

    logic [WIDTH-1:0]    a_arr [NUM_REQ];
    logic [WIDTH-1:0]    b_arr [NUM_REQ];
    logic [WIDTH-1:0]    a_sel, b_sel;
    logic [ID_W-1:0]     winner;
    logic [NUM_REQ-1:0]  grant;
    logic                found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan starting at rr_ptr and wrapping; the first valid requester wins.
    always_comb begin : winner_scan
        int idx;
        found  = 1'b0;
        winner = '0;
        a_sel  = '0;
        b_sel  = '0;
        grant  = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                winner     = ID_W'(idx);
                a_sel      = a_arr[idx];
                b_sel      = b_arr[idx];
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        resp_id_d    = resp_id_q;
        add_r1_d     = add_r1_q;
        add_r2_d     = add_r2_q;
        resp_sum_d   = resp_sum_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    add_r1_d  = a_sel;
                    add_r2_d  = b_sel;
                    resp_id_d = winner;
                    rr_ptr_d  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                // Adder inputs have been stable for a full cycle; sample its result.
                resp_sum_d   = add_rst;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            resp_id_q    <= '0;
            add_r1_q     <= '0;
            add_r2_q     <= '0;
            resp_sum_q   <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_id_q    <= resp_id_d;
            add_r1_q     <= add_r1_d;
            add_r2_q     <= add_r2_d;
            resp_sum_q   <= resp_sum_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == IDLE) ? grant : '0;
    assign add_r1     = add_r1_q;
    assign add_r2     = add_r2_q;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != IDLE);

endmodule
